inv_sb_seq: RTL

INV_SB_SEQ -- requirements
Module: inv_sb_seq

---
 rtl/inv_sb_seq_pkg.sv | 29 ++
 rtl/inv_sb_lane.sv | 33 +++
 rtl/inv_sb_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/inv_sb_seq_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : inv_sb_seq_pkg                                               |
// | Purpose  : Shared types and constants for the bit-sliced S-box          |
// |            sequencer: FSM state enum, column count and the two          |
// |            16-entry substitution tables.                                |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

package inv_sb_seq_pkg;

  // Number of 4-bit columns in the 128-bit state (one per bit of a word)
  localparam int NCOL = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tables are packed with entry i in bits [4*i+3 : 4*i]
  // Inverse: 0..F -> 0,2,4,D,8,A,B,6,1,7,5,E,F,9,C,3
  localparam logic [63:0] INV_SBOX_TBL = 64'h3C9F_E571_6BA8_D420;
  // Forward: 0..F -> 0,8,1,F,2,A,7,9,4,D,5,6,E,3,B,C
  localparam logic [63:0] FWD_SBOX_TBL = 64'hCB3E_65D4_97A2_F180;

endpackage

`default_nettype wire

// File: rtl/inv_sb_lane.sv
// ---------------------------------------------------------------------------
// | Module   : inv_sb_lane                                                  |
// | Purpose  : One combinational 4-bit S-box substitution. With             |
// |            INV_SB_SEQ_FWD_EN defined a fwd select picks between the     |
// |            forward and inverse tables; otherwise inverse only.          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module inv_sb_lane
  import inv_sb_seq_pkg::*;
(
  input  logic [3:0] din,
`ifdef INV_SB_SEQ_FWD_EN
  input  logic       fwd,
`endif
  output logic [3:0] dout
);

  // Table lookup: nibble value selects a 4-bit slice of the packed table
`ifdef INV_SB_SEQ_FWD_EN
  always_comb begin
    dout = fwd ? FWD_SBOX_TBL[{din, 2'b00} +: 4] : INV_SBOX_TBL[{din, 2'b00} +: 4];
  end
`else
  always_comb begin
    dout = INV_SBOX_TBL[{din, 2'b00} +: 4];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/inv_sb_seq.sv
// ---------------------------------------------------------------------------
// | Module   : inv_sb_seq                                                   |
// | Purpose  : Sequential bit-sliced S-box over a 128-bit state. Column j   |
// |            is {w3[j],w2[j],w1[j],w0[j]}; LANES columns are substituted  |
// |            in place per cycle, giving a latency of 32/LANES cycles.     |
// | Config   : INV_SB_SEQ_FWD_EN adds a fwd port selecting forward S-box.   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module inv_sb_seq
  import inv_sb_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_SB_SEQ_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Column step wraps to 0 for LANES=32, leaving col pinned at 0
  localparam logic [4:0] STEP     = 5'(LANES);
  localparam logic [4:0] LAST_COL = 5'(NCOL - LANES);

  state_t               state_q, state_d;
  logic [4:0]           col_q;
  logic [127:0]         work_q, work_d;
  logic                 accept;
  logic                 last_grp;

  logic [31:0]          w0, w1, w2, w3;
  logic [31:0]          nw0, nw1, nw2, nw3;
  logic [LANES-1:0]     g0, g1, g2, g3;
  logic [LANES-1:0]     n0, n1, n2, n3;
  logic [LANES-1:0][3:0] lane_in, lane_out;

`ifdef INV_SB_SEQ_FWD_EN
  logic                 fwd_q;
`endif

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_grp  = (col_q == LAST_COL);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_state = work_q;

  assign w0 = work_q[31:0];
  assign w1 = work_q[63:32];
  assign w2 = work_q[95:64];
  assign w3 = work_q[127:96];

  // Column mux: pick the current group of LANES bits from each word
  always_comb begin
    g0 = w0[col_q +: LANES];
    g1 = w1[col_q +: LANES];
    g2 = w2[col_q +: LANES];
    g3 = w3[col_q +: LANES];
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_in[i] = {g3[i], g2[i], g1[i], g0[i]};

      inv_sb_lane u_lane (
        .din  (lane_in[i]),
`ifdef INV_SB_SEQ_FWD_EN
        .fwd  (fwd_q),
`endif
        .dout (lane_out[i])
      );

      assign n0[i] = lane_out[i][0];
      assign n1[i] = lane_out[i][1];
      assign n2[i] = lane_out[i][2];
      assign n3[i] = lane_out[i][3];
    end
  endgenerate

  // Working register next value: load on accept, write substituted group back in RUN
  always_comb begin
    nw0    = w0;
    nw1    = w1;
    nw2    = w2;
    nw3    = w3;
    work_d = work_q;
    if (accept) begin
      work_d = in_state;
    end else if (state_q == RUN) begin
      nw0[col_q +: LANES] = n0;
      nw1[col_q +: LANES] = n1;
      nw2[col_q +: LANES] = n2;
      nw3[col_q +: LANES] = n3;
      work_d = {nw3, nw2, nw1, nw0};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; in_valid only matters in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath registers: working state and column counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      col_q  <= '0;
    end else begin
      work_q <= work_d;
      if (accept) begin
        col_q <= '0;
      end else if (state_q == RUN) begin
        col_q <= col_q + STEP;
      end
    end
  end

`ifdef INV_SB_SEQ_FWD_EN
  // Direction select captured with the state so it holds for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
    end else if (accept) begin
      fwd_q <= fwd;
    end
  end
`endif

endmodule

`default_nettype wire
